// File: rtl/uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// uart_tx_serializer
//
// Purpose:
//   Transmit half of the SoC UART. Takes the byte, parity enable and start
//   request from the UART register block and serialises one frame onto the TX
//   line: start bit (0), 8 data bits LSB first, optional even-parity bit, and
//   one stop bit (1). Reports busy and a one-cycle completion pulse back to
//   the register block.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per UART bit (default 434 = 50 MHz / 115200).
//                 Must be >= 2.
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous reset, active low
//   Tx_Start      transmit request level; a frame starts on its rising edge
//   Tx_Data[7:0]  byte to transmit, captured at frame start
//   Parity        1 = append an even-parity bit, captured at frame start
//   tx            serial output, idles high (registered)
//   tx_send       high from the start bit through the stop bit (registered)
//   UART_Tx_Done  one-cycle pulse in the first idle cycle after a stop bit
// -----------------------------------------------------------------------------
module uart_tx_serializer #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Tx_Start,
    input  logic [7:0] Tx_Data,
    input  logic       Parity,
    output logic       tx,
    output logic       tx_send,
    output logic       UART_Tx_Done
);

    // The baud counter only has to reach CLKS_PER_BIT-1. Keep it at least one
    // bit wide so the degenerate CLKS_PER_BIT=2 case still elaborates cleanly.
    localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t            r_state;
    logic [BAUD_W-1:0] r_baud_cnt;
    logic [2:0]        r_bit_cnt;
    logic [7:0]        r_shift;
    logic              r_par_en;
    logic              r_par_bit;
    logic              r_tx_start_q;
    logic              r_tx;
    logic              r_tx_send;
    logic              r_done;

    logic              w_start_edge;
    logic              w_bit_end;

    // Rising-edge detect on the request level. r_tx_start_q comes out of reset
    // high, so a request already high when reset is released is not mistaken
    // for a new edge; the requester must drop and re-raise it.
    assign w_start_edge = Tx_Start & ~r_tx_start_q;

    // Last cycle of the current bit period.
    assign w_bit_end = (r_baud_cnt == BAUD_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_baud_cnt   <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_par_en     <= 1'b0;
            r_par_bit    <= 1'b0;
            r_tx_start_q <= 1'b1;
            r_tx         <= 1'b1;
            r_tx_send    <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_tx_start_q <= Tx_Start;
            // Done is a single-cycle pulse; only the STOP exit raises it.
            r_done       <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_tx       <= 1'b1;
                    r_baud_cnt <= '0;
                    r_bit_cnt  <= '0;
                    if (w_start_edge) begin
                        // Everything the frame needs is captured here, so the
                        // register block may change its outputs mid-frame.
                        r_state   <= S_START;
                        r_tx      <= 1'b0;
                        r_tx_send <= 1'b1;
                        r_shift   <= Tx_Data;
                        r_par_en  <= Parity;
                        r_par_bit <= ^Tx_Data;
                    end
                end

                S_START: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        r_bit_cnt  <= '0;
                        r_state    <= S_DATA;
                        r_tx       <= r_shift[0];
                    end else begin
                        r_baud_cnt <= r_baud_cnt + BAUD_W'(1);
                    end
                end

                S_DATA: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        // 3-bit counter wraps 7 -> 0 as DATA is left.
                        r_bit_cnt  <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            if (r_par_en) begin
                                r_state <= S_PARITY;
                                r_tx    <= r_par_bit;
                            end else begin
                                r_state <= S_STOP;
                                r_tx    <= 1'b1;
                            end
                        end else begin
                            // Shift right so the next bit to send is always
                            // available at r_shift[1] while bit 0 is on the line.
                            r_shift <= {1'b0, r_shift[7:1]};
                            r_tx    <= r_shift[1];
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + BAUD_W'(1);
                    end
                end

                S_PARITY: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        r_state    <= S_STOP;
                        r_tx       <= 1'b1;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + BAUD_W'(1);
                    end
                end

                S_STOP: begin
                    if (w_bit_end) begin
                        // Back to idle: busy drops and done pulses on the same
                        // edge. A new request edge is accepted from the very
                        // next cycle, giving one idle-high cycle between frames.
                        r_baud_cnt <= '0;
                        r_state    <= S_IDLE;
                        r_tx       <= 1'b1;
                        r_tx_send  <= 1'b0;
                        r_done     <= 1'b1;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + BAUD_W'(1);
                    end
                end

                default: begin
                    r_state    <= S_IDLE;
                    r_baud_cnt <= '0;
                    r_bit_cnt  <= '0;
                    r_tx       <= 1'b1;
                    r_tx_send  <= 1'b0;
                end
            endcase
        end
    end

    assign tx           = r_tx;
    assign tx_send      = r_tx_send;
    assign UART_Tx_Done = r_done;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_serializer
//
// Directed bench for uart_tx_serializer with CLKS_PER_BIT = 4. A monitor
// records tx / tx_send / UART_Tx_Done 1 ns after every rising clock edge into
// arrays indexed by edge number; the stimulus block drives inputs on falling
// edges and then checks the recorded history against hand-written frames.
// -----------------------------------------------------------------------------
module tb_uart_tx_serializer;

    localparam int CPB   = 4;
    localparam int DEPTH = 4096;

    logic       clk;
    logic       rst;
    logic       Tx_Start;
    logic [7:0] Tx_Data;
    logic       Parity;
    logic       tx;
    logic       tx_send;
    logic       UART_Tx_Done;

    bit         clk_run;
    int         cyc;
    int         n_tests;
    int         n_fail;

    logic       m_tx   [0:DEPTH-1];
    logic       m_busy [0:DEPTH-1];
    logic       m_done [0:DEPTH-1];

    uart_tx_serializer #(.CLKS_PER_BIT(CPB)) dut (
        .clk          (clk),
        .rst          (rst),
        .Tx_Start     (Tx_Start),
        .Tx_Data      (Tx_Data),
        .Parity       (Parity),
        .tx           (tx),
        .tx_send      (tx_send),
        .UART_Tx_Done (UART_Tx_Done)
    );

    initial begin
        clk     = 1'b0;
        clk_run = 1'b0;
        cyc     = 0;
        n_tests = 0;
        n_fail  = 0;
    end

    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    // Entry k holds the outputs as they stand after rising edge number k.
    always @(posedge clk) begin
        #1;
        if (cyc < DEPTH) begin
            m_tx[cyc]   = tx;
            m_busy[cyc] = tx_send;
            m_done[cyc] = UART_Tx_Done;
        end
        cyc = cyc + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait on falling edges until edge number k is the next rising edge.
    task automatic wait_to(input int k);
        while (cyc < k) @(negedge clk);
    endtask

    function automatic int cnt_busy(input int a, input int b);
        int n = 0;
        for (int i = a; i <= b; i++) if (m_busy[i] === 1'b1) n++;
        return n;
    endfunction

    function automatic int cnt_done(input int a, input int b);
        int n = 0;
        for (int i = a; i <= b; i++) if (m_done[i] === 1'b1) n++;
        return n;
    endfunction

    function automatic int cnt_tx_high(input int a, input int b);
        int n = 0;
        for (int i = a; i <= b; i++) if (m_tx[i] === 1'b1) n++;
        return n;
    endfunction

    // bits[i] is the i-th bit on the line (bit 0 = start bit).
    task automatic check_frame(input string tag, input int base, input logic [10:0] bits, input int nbits);
        int len;
        int nmatch;
        len = nbits * CPB;
        for (int b = 0; b < nbits; b++) begin
            nmatch = 0;
            for (int c = 0; c < CPB; c++)
                if (m_tx[base + b*CPB + c] === bits[b]) nmatch++;
            chk($sformatf("%s_bit%0d", tag, b), nmatch, CPB);
        end
        chk($sformatf("%s_busy_before", tag), m_busy[base-1], 1'b0);
        chk($sformatf("%s_busy_len", tag), cnt_busy(base, base+len-1), len);
        chk($sformatf("%s_busy_after", tag), m_busy[base+len], 1'b0);
        chk($sformatf("%s_done_early", tag), cnt_done(base, base+len-1), 0);
        chk($sformatf("%s_done_pulse", tag), m_done[base+len], 1'b1);
        $display("[TB] frame %s: base=%0d bits=%0d checked, tests=%0d failed=%0d",
                 tag, base, nbits, n_tests, n_fail);
    endtask

    initial begin
        int base;
        int base2;
        int base3;
        int rb;

        // ---------------- reset values, no clock ----------------
        rst      = 1'b1;
        Tx_Start = 1'b0;
        Tx_Data  = 8'h00;
        Parity   = 1'b0;
        #1 rst = 1'b0;
        #1;
        chk("rst_tx",   tx,           1'b1);
        chk("rst_send", tx_send,      1'b0);
        chk("rst_done", UART_Tx_Done, 1'b0);
        $display("[TB] reset without clock: tx=%0b tx_send=%0b done=%0b", tx, tx_send, UART_Tx_Done);

        clk_run = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // ---------------- basic frame 0xA5, no parity ----------------
        Tx_Data = 8'hA5; Parity = 1'b0; Tx_Start = 1'b1; base = cyc;
        wait_to(base + 1); Tx_Start = 1'b0;
        wait_to(base + 46);
        check_frame("t1_a5", base, 11'b01101001010, 10);
        chk("t1_done_cnt", cnt_done(base, base+45), 1);

        // ---------------- parity frames ----------------
        Tx_Data = 8'h07; Parity = 1'b1; Tx_Start = 1'b1; base = cyc;
        wait_to(base + 1); Tx_Start = 1'b0;
        wait_to(base + 50);
        check_frame("t2_07p", base, 11'b11000001110, 11);

        Tx_Data = 8'h03; Parity = 1'b1; Tx_Start = 1'b1; base = cyc;
        wait_to(base + 1); Tx_Start = 1'b0;
        wait_to(base + 50);
        check_frame("t2_03p", base, 11'b10000000110, 11);

        // ---------------- held start, data changed mid-frame ----------------
        Tx_Data = 8'hA5; Parity = 1'b0; Tx_Start = 1'b1; base = cyc;
        wait_to(base + 10); Tx_Data = 8'hFF; Parity = 1'b1;
        wait_to(base + 100); Tx_Start = 1'b0;
        wait_to(base + 110);
        check_frame("t3_hold", base, 11'b01101001010, 10);
        chk("t3_busy_total", cnt_busy(base, base+109), 40);
        chk("t3_done_total", cnt_done(base, base+109), 1);

        // ---------------- start edge while busy ----------------
        Tx_Data = 8'hA5; Parity = 1'b0; Tx_Start = 1'b1; base = cyc;
        wait_to(base + 1);  Tx_Start = 1'b0;
        wait_to(base + 20); Tx_Start = 1'b1;
        wait_to(base + 21); Tx_Start = 1'b0;
        wait_to(base + 60);
        check_frame("t4_busy_edge", base, 11'b01101001010, 10);
        chk("t4_busy_total", cnt_busy(base, base+59), 40);
        chk("t4_done_total", cnt_done(base, base+59), 1);

        // ---------------- edge in the done cycle ----------------
        Tx_Data = 8'hA5; Parity = 1'b0; Tx_Start = 1'b1; base2 = cyc;
        wait_to(base2 + 1); Tx_Start = 1'b0;
        wait_to(base2 + 41);
        Tx_Data = 8'h3C; Tx_Start = 1'b1; base3 = cyc;
        wait_to(base3 + 1); Tx_Start = 1'b0;
        wait_to(base3 + 46);
        check_frame("t4_first", base2, 11'b01101001010, 10);
        chk("t4_gap_idle", m_tx[base2+40], 1'b1);
        chk("t4_next_start", m_tx[base3], 1'b0);
        check_frame("t4_second", base3, 11'b01001111000, 10);

        // ---------------- reset mid-frame (data bit 3) ----------------
        Tx_Data = 8'hA5; Parity = 1'b0; Tx_Start = 1'b1; base = cyc;
        wait_to(base + 17);
        chk("t5_pre_tx", m_tx[base+16], 1'b0);
        chk("t5_pre_busy", m_busy[base+16], 1'b1);
        rst = 1'b0;
        #1;
        chk("t5_rst_tx",   tx,           1'b1);
        chk("t5_rst_send", tx_send,      1'b0);
        chk("t5_rst_done", UART_Tx_Done, 1'b0);
        $display("[TB] reset mid-frame: tx=%0b tx_send=%0b done=%0b", tx, tx_send, UART_Tx_Done);
        repeat (2) @(negedge clk);
        rst = 1'b1; rb = cyc;
        wait_to(rb + 20);
        chk("t5_no_frame_busy", cnt_busy(rb, rb+19), 0);
        chk("t5_no_frame_tx", cnt_tx_high(rb, rb+19), 20);
        chk("t5_no_done", cnt_done(base, rb+19), 0);
        Tx_Start = 1'b0;
        wait_to(cyc + 2);
        Tx_Start = 1'b1; base = cyc;
        wait_to(base + 1); Tx_Start = 1'b0;
        wait_to(base + 46);
        check_frame("t5_after", base, 11'b01101001010, 10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
